// File: rtl/insight_tl_c_msg_tracker.sv
// Passive TileLink C-channel monitor: reassembles ProbeAck/Release messages into
// one summary record each and queues them for the trace packer.
module insight_tl_c_msg_tracker #(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_LGSIZE = 9
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        c_valid,
  input  logic        c_ready,
  input  logic        c_corrupt,
  input  logic [63:0] c_data,
  input  logic [31:0] c_address,
  input  logic [2:0]  c_source,
  input  logic [3:0]  c_size,
  input  logic [2:0]  c_param,
  input  logic [2:0]  c_opcode,
  output logic        rec_valid,
  input  logic        rec_ready,
  output logic [2:0]  rec_opcode,
  output logic [2:0]  rec_param,
  output logic [2:0]  rec_source,
  output logic [3:0]  rec_size,
  output logic [31:0] rec_address,
  output logic [6:0]  rec_beats,
  output logic        rec_corrupt,
  output logic [63:0] rec_xsum,
  output logic        rec_err,
  output logic [15:0] drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [3:0] MAX_SZ = 4'(MAX_LGSIZE);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  param;
    logic [2:0]  source;
    logic [3:0]  size;
    logic [31:0] address;
    logic [6:0]  beats;
    logic        corrupt;
    logic [63:0] xsum;
    logic        err;
  } rec_t;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  // Only legal data opcodes with a size above one beat span multiple beats.
  function automatic logic [6:0] exp_beats(input logic [2:0] op, input logic [3:0] sz);
    logic [6:0] n;
    n = 7'd1;
    if (op[2] && op[0] && (sz > 4'd3) && (sz <= MAX_SZ)) begin
      n = 7'd1 << (sz - 4'd3);
    end else begin
      n = 7'd1;
    end
    return n;
  endfunction

  state_t      state_r;
  rec_t        acc_r;
  logic [6:0]  rem_r;
  rec_t        nxt_rec_s;
  logic [6:0]  rem_s;
  logic        fire_s;
  logic        push_s;
  logic        hdr_chg_s;

  rec_t        mem_r [FIFO_DEPTH];
  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  logic [15:0] drop_r;
  logic        empty_s;
  logic        full_s;
  logic        pop_s;
  logic        wr_en_s;
  logic        drop_s;
  rec_t        head_s;

  assign fire_s = c_valid & c_ready;
  assign hdr_chg_s = (c_opcode != acc_r.opcode) | (c_param != acc_r.param) |
                     (c_source != acc_r.source) | (c_size != acc_r.size) |
                     (c_address != acc_r.address);

  // Next accumulator value if the current cycle fires; also the record pushed on the last beat.
  always_comb begin
    nxt_rec_s = '0;
    rem_s     = 7'd0;
    if (state_r == IDLE) begin
      nxt_rec_s.opcode  = c_opcode;
      nxt_rec_s.param   = c_param;
      nxt_rec_s.source  = c_source;
      nxt_rec_s.size    = c_size;
      nxt_rec_s.address = c_address;
      nxt_rec_s.beats   = 7'd1;
      nxt_rec_s.corrupt = c_corrupt;
      nxt_rec_s.xsum    = c_opcode[0] ? c_data : 64'd0;
      nxt_rec_s.err     = ~c_opcode[2] | (c_opcode[0] & (c_size > MAX_SZ));
      rem_s             = exp_beats(c_opcode, c_size) - 7'd1;
    end else begin
      nxt_rec_s         = acc_r;
      nxt_rec_s.beats   = acc_r.beats + 7'd1;
      nxt_rec_s.corrupt = acc_r.corrupt | c_corrupt;
      nxt_rec_s.xsum    = acc_r.xsum ^ c_data;
      nxt_rec_s.err     = acc_r.err | hdr_chg_s;
      rem_s             = rem_r - 7'd1;
    end
  end

  assign push_s = fire_s & (rem_s == 7'd0);

  // Message reassembly state machine.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
      acc_r   <= '0;
      rem_r   <= 7'd0;
    end else if (fire_s) begin
      acc_r   <= nxt_rec_s;
      rem_r   <= rem_s;
      state_r <= (rem_s == 7'd0) ? IDLE : BURST;
    end
  end

  // The extra pointer bit separates full from empty when the indices match.
  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign pop_s   = ~empty_s & rec_ready;
  assign wr_en_s = push_s & (~full_s | pop_s);
  assign drop_s  = push_s & full_s & ~pop_s;

  // Record FIFO and saturating drop counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      drop_r   <= 16'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= nxt_rec_s;
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      if (drop_s && (drop_r != 16'hFFFF)) begin
        drop_r <= drop_r + 16'd1;
      end
    end
  end

  assign head_s      = mem_r[rd_ptr_r[AW-1:0]];
  assign rec_valid   = ~empty_s;
  assign rec_opcode  = head_s.opcode;
  assign rec_param   = head_s.param;
  assign rec_source  = head_s.source;
  assign rec_size    = head_s.size;
  assign rec_address = head_s.address;
  assign rec_beats   = head_s.beats;
  assign rec_corrupt = head_s.corrupt;
  assign rec_xsum    = head_s.xsum;
  assign rec_err     = head_s.err;
  assign drop_count  = drop_r;

endmodule

// File: tb/tb_insight_tl_c_msg_tracker.sv
// Randomized bench for insight_tl_c_msg_tracker: a message-level reference model
// feeds a scoreboard queue that the monitor drains as the DUT presents records.
module tb_insight_tl_c_msg_tracker;

  localparam int DEPTH = 4;
  localparam int MAXLG = 9;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        c_valid = 1'b0, c_ready = 1'b0, c_corrupt = 1'b0;
  logic [63:0] c_data = 64'd0;
  logic [31:0] c_address = 32'd0;
  logic [2:0]  c_source = 3'd0, c_param = 3'd0, c_opcode = 3'd0;
  logic [3:0]  c_size = 4'd0;
  logic        rec_ready = 1'b0;
  logic        rec_valid, rec_corrupt, rec_err;
  logic [2:0]  rec_opcode, rec_param, rec_source;
  logic [3:0]  rec_size;
  logic [31:0] rec_address;
  logic [6:0]  rec_beats;
  logic [63:0] rec_xsum;
  logic [15:0] drop_count;

  insight_tl_c_msg_tracker #(.FIFO_DEPTH(DEPTH), .MAX_LGSIZE(MAXLG)) dut (
    .clock(clock), .reset(reset), .c_valid(c_valid), .c_ready(c_ready),
    .c_corrupt(c_corrupt), .c_data(c_data), .c_address(c_address),
    .c_source(c_source), .c_size(c_size), .c_param(c_param), .c_opcode(c_opcode),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_opcode(rec_opcode),
    .rec_param(rec_param), .rec_source(rec_source), .rec_size(rec_size),
    .rec_address(rec_address), .rec_beats(rec_beats), .rec_corrupt(rec_corrupt),
    .rec_xsum(rec_xsum), .rec_err(rec_err), .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  param;
    logic [2:0]  source;
    logic [3:0]  size;
    logic [31:0] address;
    logic [6:0]  beats;
    logic        corrupt;
    logic [63:0] xsum;
    logic        err;
  } rec_t;

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  param;
    logic [2:0]  src;
    logic [3:0]  size;
    logic [31:0] addr;
    logic [63:0] data;
    logic        corrupt;
  } beat_t;

  beat_t cur_q[$];
  rec_t  exp_q[$];
  int    model_occ = 0;
  int    model_drops = 0;
  int    n_vec = 0;
  int    n_err = 0;
  int    ready_mode = 2;

  function automatic int exp_beats(int op, int sz);
    if (op < 4 || op % 2 == 0 || sz <= 3 || sz > MAXLG) return 1;
    return 1 << (sz - 3);
  endfunction

  // Summarise the collected beats of one message straight from the protocol rules.
  function automatic rec_t build_rec();
    rec_t  r;
    beat_t f;
    logic [63:0] x;
    logic cor, e;
    f = cur_q[0];
    x = 64'd0; cor = 1'b0; e = 1'b0;
    foreach (cur_q[i]) begin
      x   = x ^ cur_q[i].data;
      cor = cor | cur_q[i].corrupt;
      if (cur_q[i].op != f.op || cur_q[i].param != f.param || cur_q[i].src != f.src ||
          cur_q[i].size != f.size || cur_q[i].addr != f.addr) e = 1'b1;
    end
    if (f.op < 3'd4) e = 1'b1;
    if (f.op[0] && f.size > 4'(MAXLG)) e = 1'b1;
    r.opcode = f.op; r.param = f.param; r.source = f.src; r.size = f.size;
    r.address = f.addr; r.beats = 7'(cur_q.size()); r.corrupt = cor;
    r.xsum = f.op[0] ? x : 64'd0; r.err = e;
    return r;
  endfunction

  task automatic monitor_step();
    rec_t got, e;
    if (!reset) begin
      n_vec++;
      if (rec_valid !== (model_occ > 0)) begin
        n_err++;
        $display("FAIL rec_valid: got %b expected %b (t=%0t)", rec_valid, model_occ > 0, $time);
      end
      if (rec_valid && rec_ready) begin
        n_vec++;
        got = {rec_opcode, rec_param, rec_source, rec_size, rec_address, rec_beats,
               rec_corrupt, rec_xsum, rec_err};
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL record: got %h expected none (t=%0t)", got, $time);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            n_err++;
            $display("FAIL record: got %h expected %h (t=%0t)", got, e, $time);
          end
        end
      end
    end
  endtask

  task automatic model_step();
    beat_t b;
    bit pop_now;
    if (reset) begin
      cur_q.delete(); exp_q.delete(); model_occ = 0; model_drops = 0;
    end else begin
      pop_now = (model_occ > 0) && (rec_ready == 1'b1);
      if (c_valid && c_ready) begin
        b.op = c_opcode; b.param = c_param; b.src = c_source; b.size = c_size;
        b.addr = c_address; b.data = c_data; b.corrupt = c_corrupt;
        cur_q.push_back(b);
        if (cur_q.size() == exp_beats(int'(cur_q[0].op), int'(cur_q[0].size))) begin
          if (model_occ < DEPTH || pop_now) begin
            exp_q.push_back(build_rec());
            model_occ++;
          end else if (model_drops < 65535) begin
            model_drops++;
          end
          cur_q.delete();
        end
      end
      if (pop_now) model_occ--;
    end
  endtask

  // Monitor then model, both on the falling edge, away from the DUT's active edge.
  initial forever begin
    @(negedge clock);
    monitor_step();
    model_step();
  end

  initial forever begin
    @(posedge clock);
    #2;
    case (ready_mode)
      1: rec_ready = 1'b0;
      2: rec_ready = 1'b1;
      default: rec_ready = 1'($urandom_range(0, 1));
    endcase
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic beat(int op, int prm, int src, int sz, logic [31:0] addr,
                      logic [63:0] data, logic cor, int gaps);
    for (int g = 0; g < gaps; g++) begin
      c_valid = 1'($urandom_range(0, 1));
      c_ready = c_valid ? 1'b0 : 1'($urandom_range(0, 1));
      c_data = {$urandom, $urandom};
      c_opcode = 3'($urandom); c_source = 3'($urandom);
      c_corrupt = 1'($urandom_range(0, 1));
      tick();
    end
    c_opcode = 3'(op); c_param = 3'(prm); c_source = 3'(src); c_size = 4'(sz);
    c_address = addr; c_data = data; c_corrupt = cor;
    c_valid = 1'b1; c_ready = 1'b1;
    tick();
    c_valid = 1'b0; c_ready = 1'b0;
  endtask

  task automatic drain();
    int k;
    ready_mode = 2;
    k = 0;
    while ((model_occ > 0 || exp_q.size() > 0) && k < 200) begin
      tick();
      k++;
    end
    n_vec++;
    if (k >= 200) begin
      n_err++;
      $display("FAIL drain: got %0d records left expected 0", exp_q.size());
    end
  endtask

  initial begin
    int op, sz, nb, bad, src;
    repeat (3) tick();
    @(negedge clock);
    chk("reset rec_valid", 64'(rec_valid), 64'd0);
    chk("reset drop_count", 64'(drop_count), 64'd0);
    chk("reset rec_beats", 64'(rec_beats), 64'd0);
    chk("reset rec_xsum", rec_xsum, 64'd0);
    chk("reset rec_address", 64'(rec_address), 64'd0);
    reset = 1'b0;
    tick();

    // Single-beat Release: record one cycle after the fire.
    beat(6, 0, 2, 6, 32'h8000_0040, 64'hDEAD_BEEF_0000_1111, 1'b0, 0);
    @(negedge clock);
    chk("release valid", 64'(rec_valid), 64'd1);
    chk("release beats", 64'(rec_beats), 64'd1);
    chk("release xsum", rec_xsum, 64'd0);
    chk("release err", 64'(rec_err), 64'd0);
    tick();

    // 8-beat ReleaseData with gaps; XOR of 1..8 is 8.
    for (int i = 1; i <= 8; i++) beat(7, 0, 1, 6, 32'h8000_1000, 64'(i), 1'b0, $urandom_range(0, 3));
    @(negedge clock);
    chk("rdata valid", 64'(rec_valid), 64'd1);
    chk("rdata beats", 64'(rec_beats), 64'd8);
    chk("rdata xsum", rec_xsum, 64'd8);
    chk("rdata err", 64'(rec_err), 64'd0);
    chk("rdata corrupt", 64'(rec_corrupt), 64'd0);
    tick();

    // ProbeAckData, source changes on beat 3, corrupt on beat 2.
    for (int i = 1; i <= 4; i++) beat(5, 1, (i == 3) ? 6 : 4, 5, 32'h8000_2000, {$urandom, $urandom}, i == 2, 0);
    @(negedge clock);
    chk("pad err", 64'(rec_err), 64'd1);
    chk("pad corrupt", 64'(rec_corrupt), 64'd1);
    chk("pad source", 64'(rec_source), 64'd4);
    chk("pad beats", 64'(rec_beats), 64'd4);
    tick();

    // Overflow with the consumer stalled, then a push and pop on a full FIFO.
    drain();
    ready_mode = 1;
    for (int i = 0; i < DEPTH + 3; i++) beat(6, 0, i, 0, 32'h9000_0000 + 32'(i * 64), {$urandom, $urandom}, 1'b0, 0);
    @(negedge clock);
    chk("ovf drop_count", 64'(drop_count), 64'd3);
    chk("ovf oldest", 64'(rec_address), 64'h9000_0000);
    tick();
    ready_mode = 2;
    beat(4, 2, 5, 0, 32'h9100_0000, 64'd0, 1'b0, 0);
    @(negedge clock);
    chk("full push+pop drop_count", 64'(drop_count), 64'd3);
    tick();
    drain();

    // Reset in the middle of a burst discards the partial message.
    ready_mode = 0;
    for (int i = 0; i < 3; i++) beat(7, 0, 3, 6, 32'h8000_3000, {$urandom, $urandom}, 1'b0, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk("midreset valid", 64'(rec_valid), 64'd0);
    chk("midreset drop_count", 64'(drop_count), 64'd0);
    tick();
    beat(6, 0, 1, 6, 32'h8000_4000, 64'd0, 1'b0, 0);
    @(negedge clock);
    chk("post-reset valid", 64'(rec_valid), 64'd1);
    chk("post-reset beats", 64'(rec_beats), 64'd1);
    tick();
    drain();

    // Illegal opcode and oversize data message: single beat with err.
    beat(2, 0, 0, 3, 32'h8000_5000, {$urandom, $urandom}, 1'b0, 0);
    @(negedge clock);
    chk("op2 err", 64'(rec_err), 64'd1);
    chk("op2 beats", 64'(rec_beats), 64'd1);
    tick();
    beat(7, 0, 0, 12, 32'h8000_6000, {$urandom, $urandom}, 1'b0, 0);
    @(negedge clock);
    chk("oversize err", 64'(rec_err), 64'd1);
    chk("oversize beats", 64'(rec_beats), 64'd1);
    tick();

    // Random traffic against the reference model.
    ready_mode = 0;
    for (int m = 0; m < 120; m++) begin
      op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(4, 7));
      sz = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 7));
      src = int'($urandom_range(0, 7));
      nb = exp_beats(op, sz);
      bad = (nb > 1 && $urandom_range(0, 5) == 0) ? int'($urandom_range(1, nb - 1)) : 0;
      for (int b = 0; b < nb; b++) begin
        beat(op, 1, (b == bad && b != 0) ? (src ^ 1) : src, sz, 32'hA000_0000 + 32'(m * 512),
             {$urandom, $urandom}, 1'($urandom_range(0, 7) == 0),
             ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 2)) : 0);
      end
    end
    drain();
    chk("final drop_count", 64'(drop_count), 64'(model_drops));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
